// File: rtl/led_status_pkg.sv
// Shared definitions for the LED status controller: power-state encoding,
// fixed LED positions, prescaler width for fast simulation, and the
// battery bar-graph scaling helper.
package led_status_pkg;

  // Power / display state of the controller.
  typedef enum logic [1:0] {
    STBY  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  // LED[0] shows power/battery; the bar-graph starts right above it.
  localparam int PWR_IDX = 0;
  localparam int BAR_LO  = 1;

  // Prescaler width used when the fullchip simulation shortcut is enabled.
  localparam int FAST_DIV = 4;

  // Number of bar segments to light for a battery reading:
  // (batt * (bar_n + 1)) >> batt_w. A full-scale reading lands just below
  // bar_n + 1, so it lights exactly bar_n segments. The product is kept in
  // 64 bits, which covers battery readings up to 32 bits wide.
  function automatic logic [31:0] bar_level(input logic [31:0] batt,
                                            input int          bar_n,
                                            input int          batt_w);
    logic [63:0] prod;
    prod = 64'(batt) * 64'(bar_n + 1);
    return 32'(prod >> batt_w);
  endfunction

endpackage

// File: rtl/led_status_ctrl_blink_gen.sv
// Blink prescaler for the LED status controller: a free-running up-counter
// whose top bit gives the slow blink and whose bit two below it gives the
// fast blink (four times the slow rate). With FAST_SIM set, the counter
// shrinks to FAST_DIV bits so blinking is visible in fullchip simulation.
module blink_gen
  import led_status_pkg::*;
#(
  parameter int BLINK_DIV = 24,
  parameter int FAST_SIM  = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic slow,
  output logic fast
);

  localparam int DIV_EFF = (FAST_SIM != 0) ? FAST_DIV : BLINK_DIV;

  logic [DIV_EFF-1:0] r_cnt;

  // Free-running prescaler; wraps naturally at 2**DIV_EFF.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_EFF'(1);
    end
  end

  assign slow = r_cnt[DIV_EFF-1];
  assign fast = r_cnt[DIV_EFF-3];

endmodule

// File: rtl/led_status_ctrl.sv
// LED status controller for the Segway top level (DE0 LED bank).
//   LED[0]          power / battery indicator
//   LED[NUM_LED-2:1] battery bar-graph
//   LED[NUM_LED-1]  over-speed fault indicator
// A three-state power FSM (STBY/RUN/FAULT) chooses the display, an
// over-speed event latches a sticky fault until explicitly cleared, and
// every LED output comes straight from a register.
// Optional build macro LED_LAMP_TEST_EN adds a lamp_test input that forces
// all LEDs on while it is held; FSM, sticky fault and prescaler keep running.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int NUM_LED   = 8,
  parameter int BATT_W    = 12,
  parameter int BLINK_DIV = 24,
  parameter int FAST_SIM  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_up,
  input  logic              ovr_spd,
  input  logic              batt_low,
  input  logic [BATT_W-1:0] batt,
  input  logic              clr_faults,
`ifdef LED_LAMP_TEST_EN
  input  logic              lamp_test,
`endif
  output logic [NUM_LED-1:0] LED
);

  localparam int BAR_N     = NUM_LED - 2;
  localparam int FAULT_IDX = NUM_LED - 1;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_fault_sticky;
  logic [NUM_LED-1:0] r_led;
  logic [NUM_LED-1:0] w_led_next;
  logic               w_slow;
  logic               w_fast;
  logic [31:0]        w_level;
  logic [BAR_N-1:0]   w_bar;

  // Blink timebase.
  blink_gen #(
    .BLINK_DIV (BLINK_DIV),
    .FAST_SIM  (FAST_SIM)
  ) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .slow  (w_slow),
    .fast  (w_fast)
  );

  // Battery bar-graph: segment i is lit when the scaled level exceeds i,
  // giving a thermometer code that fills from LED[BAR_LO] upwards.
  assign w_level = bar_level(32'(batt), BAR_N, BATT_W);

  for (genvar gi = 0; gi < BAR_N; gi++) begin : g_bar
    localparam logic [31:0] SEG_IDX = gi;
    assign w_bar[gi] = (w_level > SEG_IDX);
  end

  // Power state and sticky over-speed fault; a new over-speed event beats a
  // simultaneous clear, and the fault survives a trip through STBY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= STBY;
      r_fault_sticky <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (ovr_spd) begin
        r_fault_sticky <= 1'b1;
      end else if (clr_faults) begin
        r_fault_sticky <= 1'b0;
      end
    end
  end

  // Next state and next LED pattern from the current state and inputs;
  // losing power always wins over fault handling.
  always_comb begin
    w_state_next = r_state;
    w_led_next   = '0;
    case (r_state)
      STBY: begin
        if (pwr_up) begin
          w_state_next = RUN;
        end
        w_led_next[PWR_IDX] = w_slow;
      end
      RUN: begin
        if (!pwr_up) begin
          w_state_next = STBY;
        end else if (r_fault_sticky) begin
          w_state_next = FAULT;
        end
        w_led_next[PWR_IDX]              = batt_low ? w_slow : 1'b1;
        w_led_next[FAULT_IDX-1:BAR_LO]   = w_bar;
      end
      FAULT: begin
        if (!pwr_up) begin
          w_state_next = STBY;
        end else if (!r_fault_sticky) begin
          w_state_next = RUN;
        end
        w_led_next[PWR_IDX]              = batt_low ? w_slow : 1'b1;
        w_led_next[FAULT_IDX-1:BAR_LO]   = w_bar;
        w_led_next[FAULT_IDX]            = w_fast;
      end
      default: begin
        w_state_next = STBY;
      end
    endcase
`ifdef LED_LAMP_TEST_EN
    // Lamp test overrides only the display, never the state machine.
    if (lamp_test) begin
      w_led_next = '1;
    end
`endif
  end

  // Output register so the LED bank is driven glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign LED = r_led;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl (NUM_LED=8, BATT_W=12, FAST_SIM=1).
// The stimulus process drives directed vectors and pushes the hand-derived
// LED value expected after a given clock edge into a scoreboard queue; a
// monitor process samples LED on every falling edge and checks any entry
// due for that cycle. Blinking bits are marked in the entry and resolved
// against a 4-bit phase counter that restarts with reset.
// Define LED_LAMP_TEST_EN to also exercise the lamp-test input.
module tb_led_status_ctrl;

  typedef struct {
    int         at;
    logic [7:0] val;
    logic [7:0] slow_m;
    logic [7:0] fast_m;
    string      name;
  } exp_t;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        pwr_up     = 1'b0;
  logic        ovr_spd    = 1'b0;
  logic        batt_low   = 1'b0;
  logic        clr_faults = 1'b0;
  logic [11:0] batt       = 12'h000;
`ifdef LED_LAMP_TEST_EN
  logic        lamp_test  = 1'b0;
`endif
  logic [7:0]  LED;

  int          cyc     = 0;
  logic [3:0]  ph      = 4'd0;
  logic [3:0]  ph_last = 4'd0;
  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic        end_req  = 1'b0;
  logic        end_ack  = 1'b0;
  exp_t        cur;
  logic [7:0]  want;

  // Hand-derived patterns (bar level -> bits 1..level, plus LED[0]).
  localparam logic [7:0] P_STBY  = 8'h00; // bit0 blinks slow
  localparam logic [7:0] P_800   = 8'h0F; // level 3
  localparam logic [7:0] P_FFF   = 8'h7F; // level 6
  localparam logic [7:0] P_249   = 8'h01; // level 0
  localparam logic [7:0] P_24A   = 8'h03; // level 1
  localparam logic [7:0] P_C00   = 8'h3F; // level 5
  localparam logic [7:0] P_LOW   = 8'h0E; // level 3, bit0 blinks slow
  localparam logic [7:0] M_SLOW  = 8'h01;
  localparam logic [7:0] M_FAST  = 8'h80;

  led_status_ctrl #(
    .NUM_LED   (8),
    .BATT_W    (12),
    .BLINK_DIV (24),
    .FAST_SIM  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwr_up     (pwr_up),
    .ovr_spd    (ovr_spd),
    .batt_low   (batt_low),
    .batt       (batt),
    .clr_faults (clr_faults),
`ifdef LED_LAMP_TEST_EN
    .lamp_test  (lamp_test),
`endif
    .LED        (LED)
  );

  always #5 clk = ~clk;

  // Cycle count and prescaler phase as seen before each edge.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ph_last <= ph;
    ph      <= rst_n ? ph + 4'd1 : 4'd0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int off, input logic [7:0] v, input logic [7:0] sm,
                      input logic [7:0] fm, input string nm);
    exp_t e;
    e.at     = cyc + off;
    e.val    = v;
    e.slow_m = sm;
    e.fast_m = fm;
    e.name   = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every scoreboard entry due at this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at <= cyc) begin
        cur  = sb.pop_front();
        want = (cur.val & ~(cur.slow_m | cur.fast_m))
             | (cur.slow_m & {8{ph_last[3]}})
             | (cur.fast_m & {8{ph_last[1]}});
        checks++;
        if (cur.at != cyc) begin
          failures++;
          $display("FAIL %s: entry for cycle %0d not sampled (now %0d)",
                   cur.name, cur.at, cyc);
        end else if (LED !== want) begin
          failures++;
          $display("FAIL %s cyc=%0d: LED=%b required %b",
                   cur.name, cyc, LED, want);
        end else begin
          $display("check %s cyc=%0d LED=%b ok", cur.name, cyc, LED);
        end
      end
      if (end_req && !end_ack) begin
        while (sb.size() != 0) begin
          cur = sb.pop_front();
          checks++;
          failures++;
          $display("FAIL %s: still pending at end (due %0d, LED=%b required %b)",
                   cur.name, cur.at, LED, cur.val);
        end
        end_ack = 1'b1;
      end
    end
  end

  // Stimulus.
  initial begin
    // Reset held for two edges.
    push(1, 8'h00, 8'h00, 8'h00, "reset_a");
    push(2, 8'h00, 8'h00, 8'h00, "reset_b");
    tick(2);

    // Release in standby: LED[0] slow blink, everything else dark.
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) push(k, P_STBY, M_SLOW, 8'h00, "stby_blink");
    tick(16);

    // Power up with half battery: one edge for state, one for LED.
    pwr_up = 1'b1;
    batt   = 12'h800;
    push(1, P_STBY, M_SLOW, 8'h00, "pwrup_lag");
    push(2, P_800, 8'h00, 8'h00, "run_800");
    tick(2);
    batt = 12'hFFF; push(1, P_FFF, 8'h00, 8'h00, "run_fff"); tick(1);
    batt = 12'h249; push(1, P_249, 8'h00, 8'h00, "run_249"); tick(1);
    batt = 12'h24A; push(1, P_24A, 8'h00, 8'h00, "run_24a"); tick(1);
    batt = 12'hC00; push(1, P_C00, 8'h00, 8'h00, "run_c00"); tick(1);
    batt = 12'h800; push(1, P_800, 8'h00, 8'h00, "run_800b"); tick(1);

    // One-cycle over-speed pulse: sticky, then FAULT, then fast blink.
    ovr_spd = 1'b1;
    push(1, P_800, 8'h00, 8'h00, "ovr_pulse");
    tick(1);
    ovr_spd = 1'b0;
    push(1, P_800, 8'h00, 8'h00, "fault_lag");
    for (int k = 2; k <= 9; k++) push(k, P_800, 8'h00, M_FAST, "fault_blink");
    tick(9);

    // Clear while over-speed still asserted: fault must persist.
    ovr_spd    = 1'b1;
    clr_faults = 1'b1;
    push(1, P_800, 8'h00, M_FAST, "clr_blocked_a");
    tick(1);
    ovr_spd    = 1'b0;
    clr_faults = 1'b0;
    push(1, P_800, 8'h00, M_FAST, "clr_blocked_b");
    push(2, P_800, 8'h00, M_FAST, "clr_blocked_c");
    tick(2);

    // Real clear: sticky drops, then RUN, then fault LED off.
    clr_faults = 1'b1;
    push(1, P_800, 8'h00, M_FAST, "clr_lag_a");
    tick(1);
    clr_faults = 1'b0;
    push(1, P_800, 8'h00, M_FAST, "clr_lag_b");
    push(2, P_800, 8'h00, 8'h00, "clr_run_a");
    push(3, P_800, 8'h00, 8'h00, "clr_run_b");
    tick(3);

    // Battery low in RUN: LED[0] blinks with a 16-cycle period.
    batt_low = 1'b1;
    for (int k = 1; k <= 16; k++) push(k, P_LOW, M_SLOW, 8'h00, "batt_low");
    tick(16);

    // Back into FAULT.
    batt_low = 1'b0;
    ovr_spd  = 1'b1;
    push(1, P_800, 8'h00, 8'h00, "refault_a");
    tick(1);
    ovr_spd = 1'b0;
    push(1, P_800, 8'h00, 8'h00, "refault_b");
    push(2, P_800, 8'h00, M_FAST, "refault_c");
    tick(2);

    // Power lost in FAULT: standby display.
    pwr_up = 1'b0;
    push(1, P_800, 8'h00, M_FAST, "pwrdn_lag");
    push(2, P_STBY, M_SLOW, 8'h00, "pwrdn_stby_a");
    push(3, P_STBY, M_SLOW, 8'h00, "pwrdn_stby_b");
    tick(3);

    // Power restored: sticky fault was retained, so FAULT display returns.
    pwr_up = 1'b1;
    push(1, P_STBY, M_SLOW, 8'h00, "repwr_lag");
    push(3, P_800, 8'h00, M_FAST, "repwr_fault_a");
    push(4, P_800, 8'h00, M_FAST, "repwr_fault_b");
    tick(4);

    // One-cycle reset in FAULT: everything back to reset values, fault lost.
    rst_n = 1'b0;
    push(1, 8'h00, 8'h00, 8'h00, "midrst");
    tick(1);
    rst_n = 1'b1;
    push(1, P_STBY, M_SLOW, 8'h00, "midrst_stby");
    push(2, P_800, 8'h00, 8'h00, "midrst_run_a");
    push(3, P_800, 8'h00, 8'h00, "midrst_run_b");
    push(4, P_800, 8'h00, 8'h00, "midrst_run_c");
    tick(4);

`ifdef LED_LAMP_TEST_EN
    // Lamp test while the FSM drops to standby underneath.
    pwr_up    = 1'b0;
    lamp_test = 1'b1;
    push(1, 8'hFF, 8'h00, 8'h00, "lamp_on");
    tick(1);
    lamp_test = 1'b0;
    push(1, P_STBY, M_SLOW, 8'h00, "lamp_off");
    tick(1);
`endif

    tick(3);
    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_ack; k++) @(posedge clk);
    if (!end_ack) begin
      $display("FAIL drain: monitor did not acknowledge end of run");
      $fatal(1, "monitor stalled");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
